// File: rtl/enable_table_loader.sv
// enable_table_loader
//   Fills the address-decoder enable table from an SPI byte stream and
//   switches the active decode configuration only on a phi2 falling edge,
//   so no 6502 cycle ever observes a half-old, half-new decode.
//
//   Command byte (first byte accepted while idle):
//     0xA<cfg> : load 128 data bytes (512 two-bit entries) into config <cfg>
//     0x5<cfg> : make <cfg> the active configuration at the next phi2 fall
//   Data byte n holds entries 4n..4n+3, least-significant pair first.
//   Entry k lands at table address {cfg, k}; k[8] is the rwbar bit.
module enable_table_loader #(
  parameter int CONFIG_BITS     = 4,
  parameter int ADDR_ENTRY_BITS = 8,
  parameter int DEFAULT_CONFIG  = 0,
  parameter int SWITCH_TIMEOUT  = 4096
) (
  input  logic                                   fpga_clk,
  input  logic                                   reset,
  input  logic                                   rx_start,
  input  logic [7:0]                             rx_data,
  input  logic                                   rx_valid,
  output logic                                   rx_ready,
  input  logic                                   phi2,
  output logic                                   tbl_we,
  output logic [CONFIG_BITS+1+ADDR_ENTRY_BITS-1:0] tbl_addr,
  output logic [1:0]                             tbl_wdata,
  output logic [CONFIG_BITS-1:0]                 active_config,
  output logic                                   busy,
  output logic                                   load_done,
  output logic                                   switch_done,
  output logic                                   err
);

  // Four entries per byte, so the byte counter is two bits narrower than
  // the entry index (rwbar + page).
  localparam int CNT_W  = ADDR_ENTRY_BITS - 1;
  localparam int TA_W   = CONFIG_BITS + 1 + ADDR_ENTRY_BITS;
  localparam int TMO_W  = (SWITCH_TIMEOUT > 1) ? $clog2(SWITCH_TIMEOUT) : 1;

  localparam logic [3:0]           CMD_LOAD   = 4'hA;
  localparam logic [3:0]           CMD_SELECT = 4'h5;
  localparam logic [CNT_W-1:0]     LAST_BYTE  = {CNT_W{1'b1}};
  localparam logic [TMO_W-1:0]     TMO_LAST   = TMO_W'(SWITCH_TIMEOUT - 1);
  localparam logic [CONFIG_BITS-1:0] CFG_RST  = CONFIG_BITS'(DEFAULT_CONFIG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD_RX,
    S_LOAD_WR,
    S_SWITCH_WAIT
  } state_t;

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_t                 r_state;
  logic [CONFIG_BITS-1:0] r_cfg;        // config being loaded
  logic [CONFIG_BITS-1:0] r_target;     // config waiting to become active
  logic [7:0]             r_byte;       // data byte being unpacked
  logic [CNT_W-1:0]       r_byte_cnt;   // data byte index within the load
  logic [1:0]             r_sub;        // entry within byte now on the port
  logic [TMO_W-1:0]       r_tmo;        // cycles spent waiting for phi2

  logic                   r_phi2_meta;
  logic                   r_phi2_sync;
  logic                   r_phi2_prev;

  // Registered outputs
  logic                   r_rx_ready;
  logic                   r_tbl_we;
  logic [TA_W-1:0]        r_tbl_addr;
  logic [1:0]             r_tbl_wdata;
  logic [CONFIG_BITS-1:0] r_active_config;
  logic                   r_busy;
  logic                   r_load_done;
  logic                   r_switch_done;
  logic                   r_err;

  // ---------------------------------------------------------------------
  // Next-state values
  // ---------------------------------------------------------------------
  state_t                 w_state_next;
  logic [CONFIG_BITS-1:0] w_cfg_next;
  logic [CONFIG_BITS-1:0] w_target_next;
  logic [7:0]             w_byte_next;
  logic [CNT_W-1:0]       w_cnt_next;
  logic [1:0]             w_sub_next;
  logic [TMO_W-1:0]       w_tmo_next;
  logic                   w_tbl_we_next;
  logic [TA_W-1:0]        w_tbl_addr_next;
  logic [1:0]             w_tbl_wdata_next;
  logic [CONFIG_BITS-1:0] w_active_next;
  logic                   w_load_done_next;
  logic                   w_switch_done_next;
  logic                   w_err_next;

  logic                   w_accept;
  logic                   w_phi2_fall;
  logic [1:0]             w_sub_inc;
  logic [7:0]             w_byte_shift;

  assign w_accept     = rx_valid & r_rx_ready;
  assign w_phi2_fall  = r_phi2_prev & ~r_phi2_sync;
  assign w_sub_inc    = r_sub + 2'd1;
  assign w_byte_shift = r_byte >> {w_sub_inc, 1'b0};

  // Synchronise phi2 into the fpga_clk domain and keep one delayed copy
  // for falling-edge detection.
  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      r_phi2_meta <= 1'b0;
      r_phi2_sync <= 1'b0;
      r_phi2_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the value from
      // before the edge; blocking here would collapse the synchroniser chain.
      r_phi2_meta <= phi2;
      r_phi2_sync <= r_phi2_meta;
      r_phi2_prev <= r_phi2_sync;
    end
  end

  // FSM state register plus all registered outputs.
  always_ff @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_cfg           <= '0;
      r_target        <= '0;
      r_byte          <= '0;
      r_byte_cnt      <= '0;
      r_sub           <= '0;
      r_tmo           <= '0;
      r_rx_ready      <= 1'b1;
      r_tbl_we        <= 1'b0;
      r_tbl_addr      <= '0;
      r_tbl_wdata     <= '0;
      r_active_config <= CFG_RST;
      r_busy          <= 1'b0;
      r_load_done     <= 1'b0;
      r_switch_done   <= 1'b0;
      r_err           <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_cfg           <= w_cfg_next;
      r_target        <= w_target_next;
      r_byte          <= w_byte_next;
      r_byte_cnt      <= w_cnt_next;
      r_sub           <= w_sub_next;
      r_tmo           <= w_tmo_next;
      r_rx_ready      <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD_RX);
      r_tbl_we        <= w_tbl_we_next;
      r_tbl_addr      <= w_tbl_addr_next;
      r_tbl_wdata     <= w_tbl_wdata_next;
      r_active_config <= w_active_next;
      r_busy          <= (w_state_next != S_IDLE);
      r_load_done     <= w_load_done_next;
      r_switch_done   <= w_switch_done_next;
      r_err           <= w_err_next;
    end
  end

  // Next-state and next-output decode for the command / load / switch FSM.
  always_comb begin
    // NOTE: every variable gets a default before the case so that no path
    // leaves one unassigned, which would infer a latch.
    w_state_next       = r_state;
    w_cfg_next         = r_cfg;
    w_target_next      = r_target;
    w_byte_next        = r_byte;
    w_cnt_next         = r_byte_cnt;
    w_sub_next         = r_sub;
    w_tmo_next         = r_tmo;
    w_tbl_we_next      = 1'b0;
    w_tbl_addr_next    = r_tbl_addr;
    w_tbl_wdata_next   = r_tbl_wdata;
    w_active_next      = r_active_config;
    w_load_done_next   = 1'b0;
    w_switch_done_next = 1'b0;
    w_err_next         = 1'b0;

    case (r_state)
      S_IDLE: begin
        // rx_start is meaningless here: the next accepted byte is a command.
        if (w_accept) begin
          case (rx_data[7:4])
            CMD_LOAD: begin
              w_cfg_next   = CONFIG_BITS'(rx_data[3:0]);
              w_cnt_next   = '0;
              w_state_next = S_LOAD_RX;
            end
            CMD_SELECT: begin
              w_target_next = CONFIG_BITS'(rx_data[3:0]);
              w_tmo_next    = '0;
              w_state_next  = S_SWITCH_WAIT;
            end
            default: w_err_next = 1'b1;
          endcase
        end
      end

      S_LOAD_RX: begin
        // A new frame aborts the load; a byte handshaked alongside it is dropped.
        if (rx_start) begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end else if (w_accept) begin
          // The first entry goes out straight from rx_data on the next cycle.
          w_byte_next      = rx_data;
          w_sub_next       = 2'd0;
          w_tbl_we_next    = 1'b1;
          w_tbl_addr_next  = {r_cfg, r_byte_cnt, 2'd0};
          w_tbl_wdata_next = rx_data[1:0];
          w_state_next     = S_LOAD_WR;
        end
      end

      S_LOAD_WR: begin
        // Entry r_sub is on the write port this cycle.
        if (rx_start) begin
          w_err_next   = 1'b1;
          w_state_next = S_IDLE;
        end else if (r_sub != 2'd3) begin
          w_sub_next       = w_sub_inc;
          w_tbl_we_next    = 1'b1;
          w_tbl_addr_next  = {r_cfg, r_byte_cnt, w_sub_inc};
          w_tbl_wdata_next = w_byte_shift[1:0];
        end else if (r_byte_cnt == LAST_BYTE) begin
          w_load_done_next = 1'b1;
          w_state_next     = S_IDLE;
        end else begin
          w_cnt_next   = r_byte_cnt + 1'b1;
          w_state_next = S_LOAD_RX;
        end
      end

      S_SWITCH_WAIT: begin
        // A switch always completes; a missing phi2 only delays it to the timeout.
        if (w_phi2_fall) begin
          w_active_next      = r_target;
          w_switch_done_next = 1'b1;
          w_state_next       = S_IDLE;
        end else if (r_tmo == TMO_LAST) begin
          w_active_next      = r_target;
          w_switch_done_next = 1'b1;
          w_err_next         = 1'b1;
          w_state_next       = S_IDLE;
        end else begin
          w_tmo_next = r_tmo + 1'b1;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  assign rx_ready      = r_rx_ready;
  assign tbl_we        = r_tbl_we;
  assign tbl_addr      = r_tbl_addr;
  assign tbl_wdata     = r_tbl_wdata;
  assign active_config = r_active_config;
  assign busy          = r_busy;
  assign load_done     = r_load_done;
  assign switch_done   = r_switch_done;
  assign err           = r_err;

endmodule

// File: tb/tb_enable_table_loader.sv
// Directed bench for enable_table_loader: full load, phi2-synchronous
// select, timed-out select, aborted load, bad command, mid-load reset.
module tb_enable_table_loader;

  localparam int TA_W = 13;

  logic              fpga_clk = 1'b0;
  logic              reset    = 1'b1;
  logic              rx_start = 1'b0;
  logic [7:0]        rx_data  = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              phi2     = 1'b0;
  logic              tbl_we;
  logic [TA_W-1:0]   tbl_addr;
  logic [1:0]        tbl_wdata;
  logic [3:0]        active_config;
  logic              busy;
  logic              load_done;
  logic              switch_done;
  logic              err;

  int n_vec  = 0;
  int n_miss = 0;

  // Observed activity, logged on the falling clock edge.
  logic [TA_W+1:0] wr_q[$];
  int n_load_done   = 0;
  int n_switch_done = 0;
  int n_err         = 0;

  // Reference phi2 synchroniser used to know when a fall is due.
  logic m_s1, m_s2, m_prev;
  logic phi2_run = 1'b0;

  enable_table_loader dut (
    .fpga_clk     (fpga_clk),
    .reset        (reset),
    .rx_start     (rx_start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .phi2         (phi2),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_wdata    (tbl_wdata),
    .active_config(active_config),
    .busy         (busy),
    .load_done    (load_done),
    .switch_done  (switch_done),
    .err          (err)
  );

  always #5 fpga_clk = ~fpga_clk;

  // phi2 at fpga_clk/16, toggling 2 ns after a falling clock edge.
  always begin
    wait (phi2_run);
    #80;
    if (phi2_run) phi2 = ~phi2;
  end

  always @(posedge fpga_clk or posedge reset) begin
    if (reset) begin
      m_s1 <= 1'b0; m_s2 <= 1'b0; m_prev <= 1'b0;
    end else begin
      m_s1 <= phi2; m_s2 <= m_s1; m_prev <= m_s2;
    end
  end

  always @(negedge fpga_clk) begin
    if (tbl_we)      wr_q.push_back({tbl_addr, tbl_wdata});
    if (load_done)   n_load_done++;
    if (switch_done) n_switch_done++;
    if (err)         n_err++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge fpga_clk);
      n++;
    end
    if (!rx_ready) begin
      check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    end else begin
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge fpga_clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic start_phi2();
    @(negedge fpga_clk);
    #2 phi2_run = 1'b1;
    @(negedge fpga_clk);
  endtask

  task automatic stop_phi2_high();
    @(negedge fpga_clk);
    #2 phi2_run = 1'b0;
    phi2 = 1'b1;
    repeat (20) @(negedge fpga_clk);
  endtask

  logic [7:0] abort_bytes [10] = '{8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h5A,
                                   8'hA5, 8'h3C, 8'hC3, 8'h96, 8'h69};

  initial begin
    int base, ld0, sd0, er0, n;
    logic [TA_W+1:0] e;
    logic [7:0] b;
    logic seen_fall;

    // ---------------- reset values ----------------
    repeat (2) @(negedge fpga_clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("rst_tbl_we",   {31'd0, tbl_we},   32'd0);
    check("rst_tbl_addr", {19'd0, tbl_addr}, 32'd0);
    check("rst_active",   {28'd0, active_config}, 32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_pulses",   {29'd0, load_done, switch_done, err}, 32'd0);
    reset = 1'b0;
    @(negedge fpga_clk);

    // ---------------- full load of config 3 ----------------
    base = wr_q.size(); ld0 = n_load_done; er0 = n_err;
    send_byte(8'hA3);
    for (int i = 0; i < 128; i++) send_byte(8'hE4);
    repeat (3) @(negedge fpga_clk);
    check("ld_done_early", {31'd0, load_done}, 32'd0);
    @(negedge fpga_clk);
    check("ld_done_at4", {31'd0, load_done}, 32'd1);
    @(negedge fpga_clk);
    check("ld_writes", wr_q.size() - base, 32'd512);
    for (int i = 0; i < 512 && base + i < wr_q.size(); i++) begin
      e = wr_q[base + i];
      check("ld_addr", {19'd0, e[TA_W+1:2]}, 32'h600 + i);
      check("ld_data", {30'd0, e[1:0]}, i % 4);
    end
    e = wr_q[wr_q.size() - 1];
    check("ld_last_addr", {19'd0, e[TA_W+1:2]}, 32'h7FF);
    check("ld_done_cnt",  n_load_done - ld0, 32'd1);
    check("ld_err_cnt",   n_err - er0, 32'd0);
    check("ld_busy_after", {31'd0, busy}, 32'd0);

    // ---------------- SELECT 7 on phi2 falling edge ----------------
    start_phi2();
    sd0 = n_switch_done; er0 = n_err;
    send_byte(8'h57);
    check("sel_busy", {31'd0, busy}, 32'd1);
    n = 0;
    seen_fall = m_prev & ~m_s2;
    while (n < 64) begin
      @(negedge fpga_clk);
      if (seen_fall) break;
      check("sel_hold", {28'd0, active_config}, 32'd0);
      seen_fall = m_prev & ~m_s2;
      n++;
    end
    check("sel_edge_seen", {31'd0, seen_fall}, 32'd1);
    check("sel_active", {28'd0, active_config}, 32'd7);
    check("sel_done",   {31'd0, switch_done},   32'd1);
    @(negedge fpga_clk);
    check("sel_done_cnt", n_switch_done - sd0, 32'd1);
    check("sel_err_cnt",  n_err - er0, 32'd0);

    // ---------------- SELECT 2 with phi2 stuck high ----------------
    stop_phi2_high();
    send_byte(8'h52);
    repeat (4095) @(negedge fpga_clk);
    check("tmo_before",      {28'd0, active_config}, 32'd7);
    check("tmo_before_done", {31'd0, switch_done},   32'd0);
    @(negedge fpga_clk);
    check("tmo_active", {28'd0, active_config}, 32'd2);
    check("tmo_done",   {31'd0, switch_done},   32'd1);
    check("tmo_err",    {31'd0, err},           32'd1);
    @(negedge fpga_clk);

    // ---------------- aborted load of config 1 ----------------
    base = wr_q.size(); er0 = n_err;
    send_byte(8'hA1);
    for (int i = 0; i < 10; i++) send_byte(abort_bytes[i]);
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge fpga_clk);
      n++;
    end
    rx_start = 1'b1;
    @(negedge fpga_clk);
    rx_start = 1'b0;
    check("abt_err",  {31'd0, err},  32'd1);
    check("abt_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge fpga_clk);
    check("abt_writes", wr_q.size() - base, 32'd40);
    for (int i = 0; i < 40 && base + i < wr_q.size(); i++) begin
      e = wr_q[base + i];
      b = abort_bytes[i / 4];
      check("abt_addr", {19'd0, e[TA_W+1:2]}, 32'h200 + i);
      check("abt_data", {30'd0, e[1:0]}, (b >> (2 * (i % 4))) & 8'h3);
    end
    check("abt_err_cnt", n_err - er0, 32'd1);

    // A following SELECT 1 proceeds normally.
    start_phi2();
    er0 = n_err;
    send_byte(8'h51);
    check("abt_sel_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!switch_done && n < 64) begin
      @(negedge fpga_clk);
      n++;
    end
    check("abt_sel_done",   {31'd0, switch_done},   32'd1);
    check("abt_sel_active", {28'd0, active_config}, 32'd1);
    check("abt_sel_err",    n_err - er0, 32'd0);
    stop_phi2_high();

    // ---------------- bad command ----------------
    base = wr_q.size();
    send_byte(8'h33);
    check("bad_err",      {31'd0, err},      32'd1);
    check("bad_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("bad_busy",     {31'd0, busy},     32'd0);
    repeat (4) @(negedge fpga_clk);
    check("bad_no_we", wr_q.size() - base, 32'd0);
    check("bad_rx_ready_later", {31'd0, rx_ready}, 32'd1);

    // ---------------- reset during LOAD_WR of byte 5 ----------------
    send_byte(8'hA9);
    for (int i = 0; i < 5; i++) send_byte(8'hC6);
    check("rst_pre_we", {31'd0, tbl_we}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_tbl_we",   {31'd0, tbl_we},   32'd0);
    check("arst_rx_ready", {31'd0, rx_ready}, 32'd1);
    check("arst_active",   {28'd0, active_config}, 32'd0);
    check("arst_busy",     {31'd0, busy},     32'd0);
    @(negedge fpga_clk);
    reset = 1'b0;
    repeat (2) @(negedge fpga_clk);
    check("post_rst_we", {31'd0, tbl_we}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/enable_table_loader.md
Name: enable_table_loader

Overview:
- Sequencer that fills and selects the RAM/bus enable table used by the address decoder.
- Accepts a byte stream from the SPI slave (host side) and unpacks it into 2-bit enable-table entries on a table write port.
- Also performs glitch-free switching of the active configuration, applied only at a phi2 falling edge so that no 6502 cycle sees a mixed decode.
- Sits between the SPI byte receiver and the enable-table RAM and decoder.

Parameters:
CONFIG_BITS, 4, width of configuration index
ADDR_ENTRY_BITS, 8, address-page index bits (256-byte granularity)
DEFAULT_CONFIG, 0, active configuration after reset
SWITCH_TIMEOUT, 4096, fpga_clk cycles to wait for a phi2 falling edge before forcing a switch

Ports:
fpga_clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high
rx_start  in  1  one-cycle strobe: new SPI frame (chip select asserted)
rx_data  in  8  received byte
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader can accept a byte; transfer when rx_valid&rx_ready
phi2  in  1  6502 phase-2 clock (asynchronous to fpga_clk)
tbl_we  out  1  table write strobe
tbl_addr  out  CONFIG_BITS+1+ADDR_ENTRY_BITS  {config, rwbar, page}
tbl_wdata  out  2  {cs_ram_en, cs_bus_en}
active_config  out  CONFIG_BITS  configuration driven to the decoder
busy  out  1  state != IDLE
load_done  out  1  one-cycle pulse, table load complete
switch_done  out  1  one-cycle pulse, active_config updated
err  out  1  one-cycle pulse: bad command, aborted load or forced switch

Behaviour:
- All outputs are registered. Reset values: rx_ready=1, tbl_we=0, tbl_addr=0, tbl_wdata=0, active_config=DEFAULT_CONFIG, busy=0, all pulses 0. State is IDLE.
- phi2 passes through a 2-flop synchroniser. A falling edge is synchronised phi2 going from 1 to 0.
- Command byte (first byte accepted in IDLE):
  - [7:4]=0xA: LOAD config [3:0].
  - [7:4]=0x5: SELECT config [3:0].
  - Any other value: err pulse, stay IDLE.
- Entries per config: 2^(ADDR_ENTRY_BITS+1) = 512. Bytes per load: 128.
- Byte n carries entries 4n..4n+3, LSB pair first: bits[1:0] is entry 4n, bits[7:6] is entry 4n+3.
- Entry k maps to tbl_addr = {cfg, k[8], k[7:0]}. k[8] is rwbar, so entries 0-255 are writes and 256-511 are reads.
- States:
  - IDLE: rx_ready=1. On accepting a 0xA command, latch cfg, clear the byte counter, go LOAD_RX. On a 0x5 command, latch the target, clear the timeout counter, go SWITCH_WAIT.
  - LOAD_RX: rx_ready=1. On accepting a byte, latch it and go LOAD_WR.
  - LOAD_WR: rx_ready=0. Four consecutive cycles with tbl_we=1, one entry per cycle. After the 4th write:
    - if the byte counter is 127, pulse load_done and go IDLE;
    - otherwise increment the counter and go LOAD_RX.
  - SWITCH_WAIT: rx_ready=0.
    - On a synchronised phi2 falling edge: active_config <= target on the next clock, pulse switch_done, go IDLE.
    - If the timeout counter reaches SWITCH_TIMEOUT-1 first: apply the switch anyway and pulse both switch_done and err.
- Throughput: 5 cycles per byte minimum (1 accept + 4 writes). A full load is at least 640 cycles.
- rx_start in LOAD_RX or LOAD_WR aborts the load:
  - err pulse, tbl_we forced 0 from the next cycle, go IDLE;
  - entries already written stay written;
  - a byte handshaked in the same cycle is discarded.
- rx_start in IDLE or SWITCH_WAIT has no effect. A switch is never aborted.
- Loading the currently active config is permitted. The decoder sees entries change as they are written; the host is responsible for loading an inactive config and then issuing SELECT.
- SELECT with target equal to active_config still waits for the phi2 edge and still pulses switch_done.
- A reset mid-operation returns to reset values immediately. A partially loaded table is not cleared.
- Counters wrap never occurs: the byte counter saturates at the terminal check, and the timeout counter is cleared on entry to SWITCH_WAIT.

Test Plan:
- Reset, then send 0xA3 followed by 128 bytes of 0xE4. Require 512 writes with tbl_wdata cycling 0,1,2,3. First tbl_addr=0x600, last=0x7FF. load_done pulses once, 4 cycles after the final byte is accepted. busy=0 afterwards.
- phi2 toggling at fpga_clk/16, send 0x57. active_config changes 0→7 only on the cycle after a synchronised phi2 falling edge. switch_done pulses. err stays 0.
- phi2 held high, send 0x52. Require active_config=2 exactly SWITCH_TIMEOUT cycles after entering SWITCH_WAIT, with switch_done and err pulsing together.
- Send 0xA1 plus 10 data bytes, then pulse rx_start. Require an err pulse, exactly 40 writes, then IDLE. A following 0x51 command is accepted normally.
- Send 0x33 in IDLE. Require an err pulse, no tbl_we, rx_ready remaining 1.
- Assert reset during LOAD_WR of byte 5. Require tbl_we=0 and rx_ready=1 asynchronously, and active_config=DEFAULT_CONFIG.
